// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: result classes, operation codes and divider states.
package ex_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;
    localparam logic [2:0] EXE_RES_MUL   = 3'b101;
    localparam logic [2:0] EXE_RES_DIV   = 3'b110;

    localparam logic [7:0] EXE_NOP_OP   = 8'h00;
    localparam logic [7:0] EXE_AND_OP   = 8'h24;
    localparam logic [7:0] EXE_OR_OP    = 8'h25;
    localparam logic [7:0] EXE_XOR_OP   = 8'h26;
    localparam logic [7:0] EXE_NOR_OP   = 8'h27;
    localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
    localparam logic [7:0] EXE_SRL_OP   = 8'h02;
    localparam logic [7:0] EXE_SRA_OP   = 8'h03;
    localparam logic [7:0] EXE_ADD_OP   = 8'h20;
    localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
    localparam logic [7:0] EXE_SUB_OP   = 8'h22;
    localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
    localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
    localparam logic [7:0] EXE_SLTU_OP  = 8'h2B;
    localparam logic [7:0] EXE_MULT_OP  = 8'h18;
    localparam logic [7:0] EXE_MULTU_OP = 8'h19;
    localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes, sign fixed up in DONE.
// state    | meaning
// IDLE     | waiting for start; magnitudes and result signs latched on start
// BUSY     | DATA_W shift/subtract steps, counter runs down to zero
// DONE     | sign-corrected quotient/remainder presented for one cycle
module ex_div
    import ex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quo_o,
    output logic [DATA_W-1:0] rem_o
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              quo_neg_q;
    logic              rem_neg_q;

    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    assign a_neg = signed_i & dividend_i[DATA_W-1];
    assign b_neg = signed_i & divisor_i[DATA_W-1];
    assign a_abs = a_neg ? -dividend_i : dividend_i;
    assign b_abs = b_neg ? -divisor_i : divisor_i;

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (abort_i) begin
            state_q <= DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_q   <= DIV_BUSY;
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        dvs_q     <= b_abs;
                        cnt_q     <= CNT_W'(DATA_W - 1);
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                    end
                end
                DIV_BUSY: begin
                    rem_q <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                    if (cnt_q == '0) begin
                        state_q <= DIV_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == DIV_BUSY);
    assign done_o = (state_q == DIV_DONE);
    assign quo_o  = quo_neg_q ? -quo_q : quo_q;
    assign rem_o  = rem_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_unit.sv
// Execute stage and EX/MEM boundary register: single-cycle logic/shift/arith/mul plus optional
// iterative divide compiled in with EX_DIV_EN (divide ops behave as unknown ops without it).
module ex_unit
    import ex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 5,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [2:0]        alusel_i,
    input  logic [7:0]        aluop_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              ovf_o
);

    localparam int M = DATA_W - 1;

    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   dif;
    logic [DATA_W-1:0]   sra_res;
    logic                add_ovf;
    logic                sub_ovf;
    logic                slt;
    logic                sltu;
    logic                mul_signed;
    logic [2*DATA_W-1:0] mul_a;
    logic [2*DATA_W-1:0] mul_b;
    logic [2*DATA_W-1:0] prod;

    logic [DATA_W-1:0]   res;
    logic [DATA_W-1:0]   hi_res;
    logic [DATA_W-1:0]   lo_res;
    logic                wreg_en;
    logic                whilo_en;
    logic                ovf_det;

    logic                div_hold;
    logic                div_done;
    logic [DATA_W-1:0]   div_quo;
    logic [DATA_W-1:0]   div_rem;

    assign shamt   = reg1_i[SHAMT_W-1:0];
    assign sum     = reg1_i + reg2_i;
    assign dif     = reg1_i - reg2_i;
    assign sra_res = $signed(reg2_i) >>> shamt;
    assign add_ovf = (reg1_i[M] == reg2_i[M]) & (sum[M] != reg1_i[M]);
    assign sub_ovf = (reg1_i[M] != reg2_i[M]) & (dif[M] != reg1_i[M]);
    assign slt     = $signed(reg1_i) < $signed(reg2_i);
    assign sltu    = reg1_i < reg2_i;

    // One multiplier serves both flavours; the low 2*DATA_W bits of the extended product are exact
    assign mul_signed = (aluop_i == EXE_MULT_OP);
    assign mul_a      = {{DATA_W{mul_signed & reg1_i[M]}}, reg1_i};
    assign mul_b      = {{DATA_W{mul_signed & reg2_i[M]}}, reg2_i};
    assign prod       = mul_a * mul_b;

`ifdef EX_DIV_EN
    logic div_op;
    logic div_zero;
    logic div_start;
    logic div_busy;

    assign div_op    = (alusel_i == EXE_RES_DIV) &&
                       (aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP);
    assign div_zero  = (reg2_i == '0);
    assign div_start = valid_i & div_op & ~div_zero & ~flush_i & ~rst & ~div_busy & ~div_done;
    assign div_hold  = div_start | div_busy;
    assign stall_req_o = div_hold;

    ex_div #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (flush_i),
        .signed_i   (aluop_i == EXE_DIV_OP),
        .dividend_i (reg1_i),
        .divisor_i  (reg2_i),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );
`else
    assign div_hold    = 1'b0;
    assign div_done    = 1'b0;
    assign div_quo     = '0;
    assign div_rem     = '0;
    assign stall_req_o = 1'b0;
`endif

    always_comb begin
        res      = '0;
        hi_res   = '0;
        lo_res   = '0;
        wreg_en  = 1'b0;
        whilo_en = 1'b0;
        ovf_det  = 1'b0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                wreg_en = 1'b1;
                case (aluop_i)
                    EXE_OR_OP:  res = reg1_i | reg2_i;
                    EXE_AND_OP: res = reg1_i & reg2_i;
                    EXE_NOR_OP: res = ~(reg1_i | reg2_i);
                    EXE_XOR_OP: res = reg1_i ^ reg2_i;
                    default:    wreg_en = 1'b0;
                endcase
            end
            EXE_RES_SHIFT: begin
                wreg_en = 1'b1;
                case (aluop_i)
                    EXE_SLL_OP: res = reg2_i << shamt;
                    EXE_SRL_OP: res = reg2_i >> shamt;
                    EXE_SRA_OP: res = sra_res;
                    default:    wreg_en = 1'b0;
                endcase
            end
            EXE_RES_ARITH: begin
                wreg_en = 1'b1;
                case (aluop_i)
                    EXE_ADD_OP: begin
                        res     = sum;
                        ovf_det = add_ovf;
                        wreg_en = ~add_ovf;
                    end
                    EXE_ADDU_OP: res = sum;
                    EXE_SUB_OP: begin
                        res     = dif;
                        ovf_det = sub_ovf;
                        wreg_en = ~sub_ovf;
                    end
                    EXE_SUBU_OP: res = dif;
                    EXE_SLT_OP:  res = {{(DATA_W-1){1'b0}}, slt};
                    EXE_SLTU_OP: res = {{(DATA_W-1){1'b0}}, sltu};
                    default:     wreg_en = 1'b0;
                endcase
            end
            EXE_RES_MUL: begin
                if (aluop_i == EXE_MULT_OP || aluop_i == EXE_MULTU_OP) begin
                    hi_res   = prod[2*DATA_W-1:DATA_W];
                    lo_res   = prod[DATA_W-1:0];
                    whilo_en = 1'b1;
                end
            end
            EXE_RES_DIV: begin
`ifdef EX_DIV_EN
                // A zero divisor never starts the FSM and completes here in one cycle
                if (div_op && div_zero) begin
                    hi_res   = reg1_i;
                    lo_res   = '1;
                    whilo_en = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] wd_d, wd_q;
    logic              wreg_d, wreg_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              whilo_d, whilo_q;
    logic [DATA_W-1:0] hi_d, hi_q;
    logic [DATA_W-1:0] lo_d, lo_q;
    logic              ovf_d, ovf_q;

    always_comb begin
        valid_d = 1'b0;
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
        ovf_d   = 1'b0;
        if (!flush_i) begin
            if (div_done) begin
                valid_d = 1'b1;
                wd_d    = wd_i;
                whilo_d = 1'b1;
                hi_d    = div_rem;
                lo_d    = div_quo;
            end else if (valid_i && !div_hold) begin
                valid_d = 1'b1;
                wd_d    = wd_i;
                wreg_d  = wreg_i & wreg_en;
                wdata_d = res;
                whilo_d = whilo_en;
                hi_d    = hi_res;
                lo_d    = lo_res;
                ovf_d   = ovf_det;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign wd_o    = wd_q;
    assign wreg_o  = wreg_q;
    assign wdata_o = wdata_q;
    assign whilo_o = whilo_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_ex_unit.sv
// Bench for ex_unit: directed cases plus random single-cycle traffic against an arithmetic model.
module tb_ex_unit;
    import ex_pkg::*;

    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  alusel_i = '0;
    logic [7:0]  aluop_i = '0;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        stall_req_o, valid_o, wreg_o, whilo_o, ovf_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_unit dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .alusel_i(alusel_i), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
        .stall_req_o(stall_req_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .ovf_o(ovf_o)
    );

    typedef struct {
        logic        valid, wreg, whilo, ovf;
        logic [4:0]  wd;
        logic [31:0] wdata, hi, lo;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] op;
    } opc_t;

    opc_t ops [0:19] = '{
        '{EXE_RES_LOGIC, EXE_OR_OP},   '{EXE_RES_LOGIC, EXE_AND_OP},
        '{EXE_RES_LOGIC, EXE_XOR_OP},  '{EXE_RES_LOGIC, EXE_NOR_OP},
        '{EXE_RES_SHIFT, EXE_SLL_OP},  '{EXE_RES_SHIFT, EXE_SRL_OP},
        '{EXE_RES_SHIFT, EXE_SRA_OP},  '{EXE_RES_ARITH, EXE_ADD_OP},
        '{EXE_RES_ARITH, EXE_ADDU_OP}, '{EXE_RES_ARITH, EXE_SUB_OP},
        '{EXE_RES_ARITH, EXE_SUBU_OP}, '{EXE_RES_ARITH, EXE_SLT_OP},
        '{EXE_RES_ARITH, EXE_SLTU_OP}, '{EXE_RES_MUL, EXE_MULT_OP},
        '{EXE_RES_MUL, EXE_MULTU_OP},  '{EXE_RES_DIV, EXE_DIV_OP},
        '{EXE_RES_DIV, EXE_DIVU_OP},   '{EXE_RES_NOP, EXE_NOP_OP},
        '{EXE_RES_LOGIC, EXE_ADD_OP},  '{3'b111, EXE_OR_OP}
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk($sformatf("%s.valid", tag), valid_o, e.valid);
        chk($sformatf("%s.wd", tag), wd_o, e.wd);
        chk($sformatf("%s.wreg", tag), wreg_o, e.wreg);
        chk($sformatf("%s.wdata", tag), wdata_o, e.wdata);
        chk($sformatf("%s.whilo", tag), whilo_o, e.whilo);
        chk($sformatf("%s.hi", tag), hi_o, e.hi);
        chk($sformatf("%s.lo", tag), lo_o, e.lo);
        chk($sformatf("%s.ovf", tag), ovf_o, e.ovf);
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    // Behavioural result of one instruction, from plain integer arithmetic on 64-bit values
    function automatic exp_t model(input logic [2:0] sel, input logic [7:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] wd, input logic wr);
        exp_t        e;
        longint      sa, sb, ua, ub, s;
        logic [63:0] t;
        e       = zero_exp();
        e.valid = 1'b1;
        e.wd    = wd;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (sel)
            EXE_RES_LOGIC: case (op)
                EXE_OR_OP:  begin e.wdata = a | b;    e.wreg = wr; end
                EXE_AND_OP: begin e.wdata = a & b;    e.wreg = wr; end
                EXE_XOR_OP: begin e.wdata = a ^ b;    e.wreg = wr; end
                EXE_NOR_OP: begin e.wdata = ~(a | b); e.wreg = wr; end
                default: ;
            endcase
            EXE_RES_SHIFT: case (op)
                EXE_SLL_OP: begin e.wdata = b << a[4:0]; e.wreg = wr; end
                EXE_SRL_OP: begin e.wdata = b >> a[4:0]; e.wreg = wr; end
                EXE_SRA_OP: begin t = sb >>> a[4:0]; e.wdata = t[31:0]; e.wreg = wr; end
                default: ;
            endcase
            EXE_RES_ARITH: case (op)
                EXE_ADD_OP, EXE_SUB_OP: begin
                    s = (op == EXE_ADD_OP) ? sa + sb : sa - sb;
                    t = s;
                    e.wdata = t[31:0];
                    e.ovf   = (s > SMAX) || (s < SMIN);
                    e.wreg  = wr & ~e.ovf;
                end
                EXE_ADDU_OP: begin t = ua + ub; e.wdata = t[31:0]; e.wreg = wr; end
                EXE_SUBU_OP: begin t = ua - ub; e.wdata = t[31:0]; e.wreg = wr; end
                EXE_SLT_OP:  begin e.wdata = (sa < sb) ? 32'd1 : 32'd0; e.wreg = wr; end
                EXE_SLTU_OP: begin e.wdata = (ua < ub) ? 32'd1 : 32'd0; e.wreg = wr; end
                default: ;
            endcase
            EXE_RES_MUL: begin
                if (op == EXE_MULT_OP || op == EXE_MULTU_OP) begin
                    if (op == EXE_MULT_OP) t = sa * sb;
                    else                   t = {32'b0, a} * {32'b0, b};
                    e.hi    = t[63:32];
                    e.lo    = t[31:0];
                    e.whilo = 1'b1;
                end
            end
`ifdef EX_DIV_EN
            EXE_RES_DIV: begin
                if (op == EXE_DIV_OP || op == EXE_DIVU_OP) begin
                    e.whilo = 1'b1;
                    if (b == 32'd0) begin
                        e.lo = 32'hFFFFFFFF;
                        e.hi = a;
                    end else begin
                        if (op == EXE_DIV_OP) begin
                            t = sa / sb; e.lo = t[31:0];
                            t = sa % sb; e.hi = t[31:0];
                        end else begin
                            t = ua / ub; e.lo = t[31:0];
                            t = ua % ub; e.hi = t[31:0];
                        end
                    end
                end
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h7FFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'hFFFFFFFF;
            4:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i  = 1'b1;
        flush_i  = 1'b0;
        alusel_i = sel;
        aluop_i  = op;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'($urandom);
        wreg_i   = 1'b1;
    endtask

    // Single-cycle instruction: no stall, result one edge later
    task automatic step1(input string tag, input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        drive(sel, op, a, b);
        e = model(sel, op, a, b, wd_i, wreg_i);
        #1;
        chk($sformatf("%s.stall", tag), stall_req_o, 1'b0);
        @(posedge clk); #1;
        chk_out(tag, e);
    endtask

`ifdef EX_DIV_EN
    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   cyc;
        int   sc;
        drive(EXE_RES_DIV, op, a, b);
        e   = model(EXE_RES_DIV, op, a, b, wd_i, wreg_i);
        cyc = 0;
        sc  = 0;
        #1;
        while (cyc < 100) begin
            if (stall_req_o) sc++;
            @(posedge clk); #1;
            cyc++;
            if (valid_o) break;
        end
        chk($sformatf("%s.latency", tag), cyc, 34);
        chk($sformatf("%s.stall_cycles", tag), sc, 33);
        chk_out(tag, e);
        valid_i = 1'b0;
    endtask
`endif

    initial begin
        exp_t pend;
        logic v, f;
        int   idx;
        logic [31:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", zero_exp());
        chk("reset.stall", stall_req_o, 1'b0);
        rst = 1'b0;

        step1("or", EXE_RES_LOGIC, EXE_OR_OP, 32'h0F0F0000, 32'h0000F0F0);
        chk("or.const", wdata_o, 32'h0F0FF0F0);
        chk("or.wreg_const", wreg_o, 1'b1);
        step1("sra", EXE_RES_SHIFT, EXE_SRA_OP, 32'd4, 32'h80000000);
        chk("sra.const", wdata_o, 32'hF8000000);
        step1("srl", EXE_RES_SHIFT, EXE_SRL_OP, 32'd4, 32'h80000000);
        chk("srl.const", wdata_o, 32'h08000000);
        step1("add_ovf", EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFFFFFF, 32'h1);
        chk("add_ovf.ovf_const", ovf_o, 1'b1);
        chk("add_ovf.wreg_const", wreg_o, 1'b0);
        step1("addu", EXE_RES_ARITH, EXE_ADDU_OP, 32'h7FFFFFFF, 32'h1);
        chk("addu.const", wdata_o, 32'h80000000);
        chk("addu.ovf_const", ovf_o, 1'b0);
        step1("sub_ovf", EXE_RES_ARITH, EXE_SUB_OP, 32'h80000000, 32'h1);
        step1("mult", EXE_RES_MUL, EXE_MULT_OP, 32'hFFFFFFFE, 32'h3);
        chk("mult.hi_const", hi_o, 32'hFFFFFFFF);
        chk("mult.lo_const", lo_o, 32'hFFFFFFFA);
        step1("nop", EXE_RES_NOP, EXE_NOP_OP, 32'h5, 32'h6);

        pend = zero_exp();
        valid_i = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            idx = $urandom_range(0, 19);
            a   = pick();
            b   = pick();
`ifdef EX_DIV_EN
            if (ops[idx].sel == EXE_RES_DIV) b = 32'd0;
`endif
            v = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 9) == 0);
            alusel_i = ops[idx].sel;
            aluop_i  = ops[idx].op;
            reg1_i   = a;
            reg2_i   = b;
            wd_i     = 5'($urandom);
            wreg_i   = 1'($urandom);
            valid_i  = v;
            flush_i  = f;
            pend = (v && !f) ? model(alusel_i, aluop_i, a, b, wd_i, wreg_i) : zero_exp();
            #1;
            chk("rnd.stall", stall_req_o, 1'b0);
            @(posedge clk); #1;
            chk_out("rnd", pend);
        end
        flush_i = 1'b0;
        valid_i = 1'b0;

        drive(EXE_RES_LOGIC, EXE_OR_OP, 32'h1, 32'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_out("rst_live", zero_exp());
        rst = 1'b0;
        valid_i = 1'b0;

`ifdef EX_DIV_EN
        run_div("div_neg", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2);
        chk("div_neg.lo_const", lo_o, 32'hFFFFFFFD);
        chk("div_neg.hi_const", hi_o, 32'hFFFFFFFF);
        step1("divu_zero", EXE_RES_DIV, EXE_DIVU_OP, 32'd7, 32'd0);
        chk("divu_zero.lo_const", lo_o, 32'hFFFFFFFF);
        chk("divu_zero.hi_const", hi_o, 32'd7);
        run_div("div_minneg", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            run_div("div_rnd", (i % 2 == 0) ? EXE_DIV_OP : EXE_DIVU_OP, a, b);
        end

        drive(EXE_RES_DIV, EXE_DIVU_OP, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        chk("flush.stall", stall_req_o, 1'b0);
        chk("flush.valid", valid_o, 1'b0);
        chk("flush.wreg", wreg_o, 1'b0);
        chk("flush.whilo", whilo_o, 1'b0);
        chk("flush.ovf", ovf_o, 1'b0);
        step1("after_flush", EXE_RES_LOGIC, EXE_OR_OP, 32'h0F0F0000, 32'h0000F0F0);
        run_div("div_after_flush", EXE_DIVU_OP, 32'd100, 32'd7);

        drive(EXE_RES_DIV, EXE_DIV_OP, 32'h12345678, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_out("rst_div", zero_exp());
        chk("rst_div.stall", stall_req_o, 1'b0);
        rst = 1'b0;
        valid_i = 1'b0;
        @(posedge clk); #1;
        step1("after_rst", EXE_RES_LOGIC, EXE_XOR_OP, 32'hFFFF0000, 32'h0F0F0F0F);
        run_div("div_after_rst", EXE_DIV_OP, 32'h12345678, 32'hFFFFFFFD);
`else
        step1("div_off", EXE_RES_DIV, EXE_DIV_OP, 32'hFFFFFFF9, 32'd2);
        chk("div_off.whilo_const", whilo_o, 1'b0);
        step1("divu_off", EXE_RES_DIV, EXE_DIVU_OP, 32'd7, 32'd0);
        chk("divu_off.lo_const", lo_o, 32'd0);
`endif
        valid_i = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
